// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and
// queues returned instructions (2 deep) for decode; handles redirect and halt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_INC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        execBranch,
  input  logic [15:0] newPc,
  input  logic        hlt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_vld,
  input  logic [15:0] imem_data,
  output logic        inst_vld,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_rdy,
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HALTED} state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_pc, w_pc_nxt;
  logic [15:0]       r_req_pc, w_req_pc_nxt;
  logic              r_drop, w_drop_nxt;
  logic [1:0]        r_count, w_count_nxt;
  logic [1:0][15:0]  r_q_inst;
  logic [1:0][15:0]  r_q_pc;

  logic       w_inst_vld, w_pop, w_push, w_issue, w_widx;
  logic [1:0] w_cnt_pp;

  // Redirect and halt both flush the queue, so neither push nor pop survives them.
  always_comb begin
    w_inst_vld = (r_count != 2'd0) && !hlt && !execBranch && (r_state != S_HALTED);
    w_pop      = w_inst_vld && inst_rdy;
    w_push     = (r_state == S_WAIT) && imem_vld && !r_drop && !hlt && !execBranch;
    w_cnt_pp   = r_count + {1'b0, w_push} - {1'b0, w_pop};
    w_widx     = (r_count - {1'b0, w_pop}) != 2'd0;
    w_issue    = rst_n && !hlt && !execBranch && (w_cnt_pp < 2'd2) &&
                 ((r_state == S_IDLE) || ((r_state == S_WAIT) && imem_vld));
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_drop_nxt   = r_drop;
    w_count_nxt  = w_cnt_pp;
    case (r_state)
      S_HALTED: w_count_nxt = 2'd0;
      S_DRAIN: begin
        w_count_nxt = 2'd0;
        if (imem_vld) w_state_nxt = S_HALTED;
      end
      default: begin
        if (hlt) begin
          w_count_nxt = 2'd0;
          w_drop_nxt  = 1'b0;
          w_state_nxt = ((r_state == S_WAIT) && !imem_vld) ? S_DRAIN : S_HALTED;
        end else if (execBranch) begin
          w_pc_nxt    = newPc;
          w_count_nxt = 2'd0;
          if (r_state == S_WAIT) begin
            // Outstanding wrong-path read: mark it for discard if not back yet.
            if (imem_vld) begin
              w_state_nxt = S_IDLE;
              w_drop_nxt  = 1'b0;
            end else begin
              w_drop_nxt  = 1'b1;
            end
          end
        end else begin
          if ((r_state == S_WAIT) && imem_vld) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
          if (w_issue) begin
            w_state_nxt  = S_WAIT;
            w_req_pc_nxt = r_pc;
            w_pc_nxt     = r_pc + 16'(PC_INC);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_drop   <= 1'b0;
      r_count  <= 2'd0;
      r_q_inst <= '0;
      r_q_pc   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_drop   <= w_drop_nxt;
      r_count  <= w_count_nxt;
      // Head only shifts when a second entry exists, so an empty head holds its last value.
      if (w_pop && (r_count == 2'd2)) begin
        r_q_inst[0] <= r_q_inst[1];
        r_q_pc[0]   <= r_q_pc[1];
      end
      if (w_push) begin
        r_q_inst[w_widx] <= imem_data;
        r_q_pc[w_widx]   <= r_req_pc;
      end
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign inst_vld  = w_inst_vld;
  assign inst      = r_q_inst[0];
  assign inst_pc   = r_q_pc[0];
  assign halted    = (r_state == S_HALTED);

endmodule
